otsu_histo_scan: RTL

- Parametrised successor of the Otsu histogram stage.
- Builds the per-frame gray histogram and the gray-weighted histogram in one dual-port RAM during the active frame.
- After the frame, a single linear prefix scan emits, for each threshold t, the class counts and class gray sums on both sides. This takes one output per cycle and 2^BIN_BITS cycles in total, instead of a quadratic re-read.
- The bins are cleared during the same scan. The block feeds the between-class-variance / argmax stage.

---
 rtl/otsu_pkg.sv | 30 +++
 rtl/histo_bin_ram.sv | 34 +++
 rtl/otsu_histo_scan.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/otsu_pkg.sv
// Shared definitions for the Otsu histogram/scan stage: FSM encoding,
// bin-mapping modes and the gray-to-bin mapping helper.
package otsu_pkg;

   localparam logic [2:0] ST_INIT  = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_STATS = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_SCAN  = 3'd4;

   localparam logic MODE_CLAMP = 1'b0;
   localparam logic MODE_SHIFT = 1'b1;

   // Clamp keeps low gray resolution exact; shift spreads the full range over the bins.
   function automatic logic [31:0] bin_map(input logic [31:0] gray,
                                           input logic        mode,
                                           input int unsigned pix_w,
                                           input int unsigned bin_bits);
      logic [31:0] max_bin;
      max_bin = (32'd1 << bin_bits) - 32'd1;
      if (mode == MODE_SHIFT) begin
         return gray >> (pix_w - bin_bits);
      end else if (gray > max_bin) begin
         return max_bin;
      end else begin
         return gray;
      end
   endfunction

endpackage

// File: rtl/histo_bin_ram.sv
// Simple dual-port bin memory: one write port, one registered read port
// with 1-cycle latency. Read-during-write ordering is handled by the parent.
module histo_bin_ram #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 47
) (
   input  logic              clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // write port
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // registered read port
   always_ff @(posedge clock) begin
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/otsu_histo_scan.sv
// Per-frame gray histogram (count + gray-weighted) built in one RAM, followed by a
// linear prefix scan emitting class counts/sums for every threshold while clearing bins.
module otsu_histo_scan
   import otsu_pkg::*;
#(
   parameter int PIX_W    = 8,
   parameter int BIN_BITS = 7,
   parameter int CNT_W    = 20,
   parameter int SUM_W    = 27
) (
   input  logic                clock,
   input  logic                rst,
   input  logic [PIX_W-1:0]    iGray,
   input  logic                hs,
   input  logic                vs,
   input  logic                de,
   input  logic                mode,
   output logic                busy,
   output logic                out_vld,
   output logic [BIN_BITS-1:0] out_thr,
   output logic                out_last,
   output logic [CNT_W-1:0]    N1,
   output logic [CNT_W-1:0]    N2,
   output logic [SUM_W-1:0]    G1,
   output logic [SUM_W-1:0]    G2,
   output logic                frame_drop
);

   localparam int DW = CNT_W + SUM_W;
   localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'((1 << BIN_BITS) - 1);
   localparam logic [BIN_BITS-1:0] BIN_ONE  = BIN_BITS'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

   logic [2:0]          r_state;
   logic                r_vs;
   logic                r_mode;
   logic [BIN_BITS-1:0] r_init_cnt;
   logic                r_flush_cnt;
   logic [BIN_BITS-1:0] r_scan_t;
   logic [CNT_W-1:0]    r_n_tot;
   logic [SUM_W-1:0]    r_g_tot;
   logic                r_run_vld;
   logic [BIN_BITS-1:0] r_run_bin;
   logic [CNT_W-1:0]    r_run_cnt;
   logic [SUM_W-1:0]    r_run_sum;
   logic                r_wr_en;
   logic [BIN_BITS-1:0] r_wr_addr;
   logic [DW-1:0]       r_wr_data;
   logic                r_fwd;
   logic [DW-1:0]       r_fwd_data;
   logic                r_srd_vld;
   logic [BIN_BITS-1:0] r_srd_t;
   logic [CNT_W-1:0]    r_pn;
   logic [SUM_W-1:0]    r_pg;
   logic                r_busy;
   logic                r_out_vld;
   logic [BIN_BITS-1:0] r_out_thr;
   logic                r_out_last;
   logic [CNT_W-1:0]    r_n1;
   logic [CNT_W-1:0]    r_n2;
   logic [SUM_W-1:0]    r_g1;
   logic [SUM_W-1:0]    r_g2;
   logic                r_frame_drop;

   logic                w_vs_rise;
   logic                w_vs_fall;
   logic                w_pix;
   logic [BIN_BITS-1:0] w_bin;
   logic [SUM_W-1:0]    w_bin_ext;
   logic                w_run_hit;
   logic                w_flush;
   logic [2:0]          w_next_state;
   logic [BIN_BITS-1:0] w_rd_addr;
   logic [DW-1:0]       w_rdata;
   logic [DW-1:0]       w_base;
   logic [CNT_W-1:0]    w_base_cnt;
   logic [SUM_W-1:0]    w_base_sum;
   logic [CNT_W-1:0]    w_pn_next;
   logic [SUM_W-1:0]    w_pg_next;
   logic                w_unused_hs;

   assign w_unused_hs = hs;

   assign w_vs_rise  = vs & ~r_vs;
   assign w_vs_fall  = ~vs & r_vs;
   assign w_pix      = (r_state == ST_STATS) & de & vs;
   assign w_bin      = BIN_BITS'(bin_map(32'(iGray), r_mode, PIX_W, BIN_BITS));
   assign w_bin_ext  = SUM_W'(w_bin);
   assign w_run_hit  = r_run_vld & w_pix & (w_bin == r_run_bin);
   assign w_flush    = r_run_vld & ~w_run_hit;

   // A read that collided with the in-flight write sees the written value instead of stale RAM data.
   assign w_base     = r_fwd ? r_fwd_data : w_rdata;
   assign w_base_cnt = w_base[DW-1:SUM_W];
   assign w_base_sum = w_base[SUM_W-1:0];
   assign w_pn_next  = r_pn + w_base_cnt;
   assign w_pg_next  = r_pg + w_base_sum;

   // next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_INIT: begin
            if (r_init_cnt == LAST_BIN) w_next_state = ST_IDLE;
            else                        w_next_state = ST_INIT;
         end
         ST_IDLE: begin
            if (w_vs_rise) w_next_state = ST_STATS;
            else           w_next_state = ST_IDLE;
         end
         ST_STATS: begin
            if (w_vs_fall) w_next_state = ST_FLUSH;
            else           w_next_state = ST_STATS;
         end
         ST_FLUSH: begin
            if (r_flush_cnt) w_next_state = ST_SCAN;
            else             w_next_state = ST_FLUSH;
         end
         ST_SCAN: begin
            if (r_scan_t == LAST_BIN) w_next_state = ST_IDLE;
            else                      w_next_state = ST_SCAN;
         end
         default: w_next_state = ST_INIT;
      endcase
   end

   // RAM read address: scan pointer, incoming pixel bin, or the held run bin
   always_comb begin
      w_rd_addr = r_run_bin;
      if (r_state == ST_SCAN) begin
         w_rd_addr = r_scan_t;
      end else if (w_pix) begin
         w_rd_addr = w_bin;
      end else begin
         w_rd_addr = r_run_bin;
      end
   end

   // FSM state, vs edge register and sequencing counters
   always_ff @(posedge clock) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_vs        <= 1'b0;
         r_mode      <= MODE_CLAMP;
         r_init_cnt  <= '0;
         r_flush_cnt <= 1'b0;
         r_scan_t    <= '0;
      end else begin
         r_state <= w_next_state;
         r_vs    <= vs;
         if ((r_state == ST_IDLE) && w_vs_rise) r_mode <= mode;
         else                                   r_mode <= r_mode;
         if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + BIN_ONE;
         else                    r_init_cnt <= '0;
         if (r_state == ST_FLUSH) r_flush_cnt <= ~r_flush_cnt;
         else                     r_flush_cnt <= 1'b0;
         if (r_state == ST_SCAN) r_scan_t <= r_scan_t + BIN_ONE;
         else                    r_scan_t <= '0;
      end
   end

   // frame totals
   always_ff @(posedge clock) begin
      if (rst) begin
         r_n_tot <= '0;
         r_g_tot <= '0;
      end else if ((r_state == ST_IDLE) && w_vs_rise) begin
         r_n_tot <= '0;
         r_g_tot <= '0;
      end else if (w_pix) begin
         r_n_tot <= r_n_tot + CNT_ONE;
         r_g_tot <= r_g_tot + w_bin_ext;
      end else begin
         r_n_tot <= r_n_tot;
         r_g_tot <= r_g_tot;
      end
   end

   // run merging of consecutive identical bins
   always_ff @(posedge clock) begin
      if (rst) begin
         r_run_vld <= 1'b0;
         r_run_bin <= '0;
         r_run_cnt <= '0;
         r_run_sum <= '0;
      end else if (w_run_hit) begin
         r_run_cnt <= r_run_cnt + CNT_ONE;
         r_run_sum <= r_run_sum + w_bin_ext;
      end else if (w_pix) begin
         r_run_vld <= 1'b1;
         r_run_bin <= w_bin;
         r_run_cnt <= CNT_ONE;
         r_run_sum <= w_bin_ext;
      end else begin
         r_run_vld <= 1'b0;
      end
   end

   // single registered write stage shared by init clear, run commit and scan clear
   always_ff @(posedge clock) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (r_state == ST_INIT) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= r_init_cnt;
         r_wr_data <= '0;
      end else if (r_state == ST_SCAN) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= r_scan_t;
         r_wr_data <= '0;
      end else if (w_flush) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= r_run_bin;
         r_wr_data <= {w_base_cnt + r_run_cnt, w_base_sum + r_run_sum};
      end else begin
         r_wr_en   <= 1'b0;
      end
   end

   // forwarding capture: remembers whether the last read hit the in-flight write
   always_ff @(posedge clock) begin
      if (rst) begin
         r_fwd      <= 1'b0;
         r_fwd_data <= '0;
      end else begin
         r_fwd      <= r_wr_en & (r_wr_addr == w_rd_addr);
         r_fwd_data <= r_wr_data;
      end
   end

   // scan read pipeline and prefix accumulators
   always_ff @(posedge clock) begin
      if (rst) begin
         r_srd_vld <= 1'b0;
         r_srd_t   <= '0;
         r_pn      <= '0;
         r_pg      <= '0;
      end else begin
         r_srd_vld <= (r_state == ST_SCAN);
         r_srd_t   <= r_scan_t;
         if (r_state == ST_FLUSH) begin
            r_pn <= '0;
            r_pg <= '0;
         end else if (r_srd_vld) begin
            r_pn <= w_pn_next;
            r_pg <= w_pg_next;
         end else begin
            r_pn <= r_pn;
            r_pg <= r_pg;
         end
      end
   end

   // registered outputs
   always_ff @(posedge clock) begin
      if (rst) begin
         r_busy       <= 1'b0;
         r_frame_drop <= 1'b0;
         r_out_vld    <= 1'b0;
         r_out_thr    <= '0;
         r_out_last   <= 1'b0;
         r_n1         <= '0;
         r_n2         <= '0;
         r_g1         <= '0;
         r_g2         <= '0;
      end else begin
         r_busy       <= (r_state != ST_IDLE);
         r_frame_drop <= w_vs_rise & (r_state != ST_IDLE);
         if (r_srd_vld) begin
            r_out_vld  <= 1'b1;
            r_out_thr  <= r_srd_t;
            r_out_last <= (r_srd_t == LAST_BIN);
            r_n1       <= w_pn_next;
            r_n2       <= r_n_tot - w_pn_next;
            r_g1       <= w_pg_next;
            r_g2       <= r_g_tot - w_pg_next;
         end else begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
         end
      end
   end

   histo_bin_ram #(
      .ADDR_W (BIN_BITS),
      .DATA_W (DW)
   ) u_ram (
      .clock   (clock),
      .i_we    (r_wr_en),
      .i_waddr (r_wr_addr),
      .i_wdata (r_wr_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rdata)
   );

   assign busy       = r_busy;
   assign out_vld    = r_out_vld;
   assign out_thr    = r_out_thr;
   assign out_last   = r_out_last;
   assign N1         = r_n1;
   assign N2         = r_n2;
   assign G1         = r_g1;
   assign G2         = r_g2;
   assign frame_drop = r_frame_drop;

endmodule
